// File: rtl/exception_sequencer.sv
// Exception sequencer: on a fault flag, saves EPC, fetches the handler byte from
// the vector table and steers the PC mux to the zero-extended handler address.
module exception_sequencer #(
    parameter int unsigned VEC_BASE = 253,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opcode_invalid,
    input  logic        ovf_flag,
    input  logic        div_zero,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_data,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic        epc_write,
    output logic [31:0] epc_out,
    output logic [1:0]  cause,
    output logic [31:0] handler_addr,
    output logic        EX_control,
    output logic        pc_write,
    output logic        busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_READ     = 2'd1;
    localparam logic [1:0] S_LOAD     = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    localparam logic [2:0]  LAST_CNT = 3'(MEM_LAT - 1);
    localparam logic [31:0] VEC_ADDR = 32'(VEC_BASE);

    logic [1:0] state;
    logic [2:0] cnt;
    logic       fault;
    logic [1:0] next_cause;

    // Fixed priority: opcode_invalid > ovf_flag > div_zero.
    always_comb begin
        fault      = opcode_invalid | ovf_flag | div_zero;
        next_cause = 2'd2;
        if (opcode_invalid)
            next_cause = 2'd0;
        else if (ovf_flag)
            next_cause = 2'd1;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 3'd0;
            cause        <= 2'd0;
            epc_out      <= 32'd0;
            mem_addr     <= 32'd0;
            handler_addr <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fault) begin
                        cause    <= next_cause;
                        epc_out  <= pc_in - 32'd4;
                        mem_addr <= VEC_ADDR + {30'd0, next_cause};
                        cnt      <= 3'd0;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= 3'd0;
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_LOAD: begin
                    handler_addr <= {24'd0, mem_data};
                    state        <= S_REDIRECT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from state only, so flag inputs never reach outputs combinationally.
    assign busy       = (state != S_IDLE);
    assign mem_rd     = (state == S_READ);
    assign epc_write  = (state == S_READ) && (cnt == 3'd0);
    assign EX_control = (state == S_REDIRECT);
    assign pc_write   = (state == S_REDIRECT);

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: two instances (MEM_LAT=1 and 3) share the flag
// inputs and are compared each cycle against a cycle-count reference model.
module tb_exception_sequencer;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        opcode_invalid, ovf_flag, div_zero;
    logic [31:0] pc_in;
    logic [7:0]  vec [256];

    logic [7:0]  mem_data     [2];
    logic        mem_rd       [2];
    logic [31:0] mem_addr     [2];
    logic        epc_write    [2];
    logic [31:0] epc_out      [2];
    logic [1:0]  cause        [2];
    logic [31:0] handler_addr [2];
    logic        EX_control   [2];
    logic        pc_write     [2];
    logic        busy         [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign mem_data[0] = vec[mem_addr[0][7:0]];
    assign mem_data[1] = vec[mem_addr[1][7:0]];

    exception_sequencer #(.VEC_BASE(253), .MEM_LAT(LAT0)) dut0 (
        .clk(clk), .reset(reset), .opcode_invalid(opcode_invalid), .ovf_flag(ovf_flag),
        .div_zero(div_zero), .pc_in(pc_in), .mem_data(mem_data[0]), .mem_rd(mem_rd[0]),
        .mem_addr(mem_addr[0]), .epc_write(epc_write[0]), .epc_out(epc_out[0]),
        .cause(cause[0]), .handler_addr(handler_addr[0]), .EX_control(EX_control[0]),
        .pc_write(pc_write[0]), .busy(busy[0]));

    exception_sequencer #(.VEC_BASE(253), .MEM_LAT(LAT1)) dut1 (
        .clk(clk), .reset(reset), .opcode_invalid(opcode_invalid), .ovf_flag(ovf_flag),
        .div_zero(div_zero), .pc_in(pc_in), .mem_data(mem_data[1]), .mem_rd(mem_rd[1]),
        .mem_addr(mem_addr[1]), .epc_write(epc_write[1]), .epc_out(epc_out[1]),
        .cause(cause[1]), .handler_addr(handler_addr[1]), .EX_control(EX_control[1]),
        .pc_write(pc_write[1]), .busy(busy[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: k = cycles since trigger edge (0 = idle).
    // Cycles 1..L read, L+1 load, L+2 redirect.
    int          lat [2] = '{LAT0, LAT1};
    int          k   [2];
    logic [1:0]  m_cause [2];
    logic [31:0] m_epc [2], m_addr [2], m_hand [2];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                k[i] = 0; m_cause[i] = 2'd0; m_epc[i] = 32'd0; m_addr[i] = 32'd0; m_hand[i] = 32'd0;
            end else if (k[i] == 0) begin
                if (opcode_invalid || ovf_flag || div_zero) begin
                    m_cause[i] = opcode_invalid ? 2'd0 : (ovf_flag ? 2'd1 : 2'd2);
                    m_epc[i]   = pc_in - 32'd4;
                    m_addr[i]  = 32'd253 + 32'(m_cause[i]);
                    k[i]       = 1;
                end
            end else begin
                if (k[i] == lat[i] + 1) m_hand[i] = {24'd0, vec[m_addr[i][7:0]]};
                k[i] = (k[i] == lat[i] + 2) ? 0 : k[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit rd_exp;
                bit red_exp;
                rd_exp  = (k[i] >= 1) && (k[i] <= lat[i]);
                red_exp = (k[i] == lat[i] + 2);
                check($sformatf("busy%0d", i),      32'(busy[i]),       32'(k[i] != 0));
                check($sformatf("mem_rd%0d", i),    32'(mem_rd[i]),     32'(rd_exp));
                check($sformatf("epc_write%0d", i), 32'(epc_write[i]),  32'(k[i] == 1));
                check($sformatf("EX_control%0d", i),32'(EX_control[i]), 32'(red_exp));
                check($sformatf("pc_write%0d", i),  32'(pc_write[i]),   32'(red_exp));
                check($sformatf("epc_out%0d", i),   epc_out[i],         m_epc[i]);
                check($sformatf("cause%0d", i),     32'(cause[i]),      32'(m_cause[i]));
                check($sformatf("handler%0d", i),   handler_addr[i],    m_hand[i]);
                if (rd_exp) check($sformatf("mem_addr%0d", i), mem_addr[i], m_addr[i]);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_flags(input logic op, input logic ov, input logic dz);
        opcode_invalid = op; ovf_flag = ov; div_zero = dz;
    endtask

    initial begin
        reset = 1'b1;
        set_flags(1'b0, 1'b0, 1'b0);
        pc_in = 32'd0;
        for (int a = 0; a < 256; a++) vec[a] = 8'($urandom);
        vec[254] = 8'h80;
        tick(2);
        check("rst_busy0", 32'(busy[0]), 32'd0);
        check("rst_epc0", epc_out[0], 32'd0);
        check("rst_handler1", handler_addr[1], 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        tick(1);

        // Overflow at pc 0x40; a second ovf pulse while busy is ignored.
        pc_in = 32'h40; set_flags(1'b0, 1'b1, 1'b0);
        tick(1);
        set_flags(1'b0, 1'b0, 1'b0);
        check("t1_epc_write", 32'(epc_write[0]), 32'd1);
        check("t1_epc", epc_out[0], 32'h3C);
        check("t1_cause", 32'(cause[0]), 32'd1);
        check("t1_addr", mem_addr[0], 32'd254);
        tick(1);
        set_flags(1'b0, 1'b1, 1'b0);
        check("t1_c2_pc_write", 32'(pc_write[0]), 32'd0);
        check("t1_c2_epc_write1", 32'(epc_write[1]), 32'd0);
        tick(1);
        set_flags(1'b0, 1'b0, 1'b0);
        check("t1_c3_ex", 32'(EX_control[0]), 32'd1);
        check("t1_c3_pcw", 32'(pc_write[0]), 32'd1);
        check("t1_handler", handler_addr[0], 32'h80);
        check("t4_c3_rd", 32'(mem_rd[1]), 32'd1);
        tick(1);
        check("t5_busy_drop", 32'(busy[0]), 32'd0);
        check("t4_c4_rd", 32'(mem_rd[1]), 32'd0);
        tick(1);
        check("t4_c5_ex", 32'(EX_control[1]), 32'd1);
        check("t4_handler", handler_addr[1], 32'h80);
        tick(2);

        // Simultaneous opcode + div-zero: opcode wins, no second sequence.
        pc_in = 32'h100; set_flags(1'b1, 1'b0, 1'b1);
        tick(1);
        set_flags(1'b0, 1'b0, 1'b0);
        check("t2_cause", 32'(cause[0]), 32'd0);
        check("t2_addr", mem_addr[0], 32'd253);
        tick(6);
        check("t2_idle0", 32'(busy[0]), 32'd0);
        check("t2_idle1", 32'(busy[1]), 32'd0);

        // Divide by zero at pc 0 wraps the EPC.
        pc_in = 32'h0; set_flags(1'b0, 1'b0, 1'b1);
        tick(1);
        set_flags(1'b0, 1'b0, 1'b0);
        check("t3_epc", epc_out[0], 32'hFFFF_FFFC);
        check("t3_addr", mem_addr[1], 32'd255);
        tick(6);

        // Reset mid-READ aborts immediately.
        pc_in = 32'h200; set_flags(1'b0, 1'b1, 1'b0);
        tick(1);
        set_flags(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t6_busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("t6_rd%0d", i), 32'(mem_rd[i]), 32'd0);
            check($sformatf("t6_pcw%0d", i), 32'(pc_write[i]), 32'd0);
            check($sformatf("t6_epc%0d", i), epc_out[i], 32'd0);
            check($sformatf("t6_hand%0d", i), handler_addr[i], 32'd0);
        end
        tick(2);
        reset = 1'b0;
        tick(1);
        pc_in = 32'h304; set_flags(1'b0, 1'b0, 1'b1);
        tick(1);
        set_flags(1'b0, 1'b0, 1'b0);
        check("t6_restart_epcw", 32'(epc_write[0]), 32'd1);
        check("t6_restart_epc", epc_out[0], 32'h300);
        tick(6);

        // Randomized phase: sparse level flags, occasional reset and table updates.
        for (int c = 0; c < 4000; c++) begin
            pc_in = $urandom;
            set_flags($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 299) == 0);
            if (k[0] == 0 && k[1] == 0 && $urandom_range(0, 3) == 0)
                vec[253 + $urandom_range(0, 2)] = 8'($urandom);
            tick(1);
        end
        reset = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0);
        tick(8);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
